cnt_bank_incdec: RTL and testbench
==================================

# cnt_bank_incdec

Parametrised bank of NUM_CH independent WIDTH-bit counters, updated by indexed pre/post increment, decrement, load and add commands over a valid/ready command port. Each accepted command returns a response (pre- or post-update value, overflow flag, error flag) over a valid/ready response port. The block is the sequential, multi-channel successor to the team's single-variable ++/-- constructs. It serves as a counter/credit store and as a stress block for indexed read-modify-write.

## Interface
- NUM_CH, default 4: number of counters; any value ≥ 1, power of two not required.
- WIDTH, default 8: counter and data width.
- IDX_W, default $clog2(NUM_CH) (minimum 1): index width.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  3  operation code (see Operation).
- cmd_idx  in  IDX_W  target counter.
- cmd_data  in  WIDTH  operand for LOAD/ADD; ignored otherwise.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  WIDTH  returned value.
- rsp_idx  out  IDX_W  index of the originating command.
- rsp_ovf  out  1  update wrapped, or saturated when CNT_BANK_SAT_EN is defined.
- rsp_err  out  1  cmd_idx ≥ NUM_CH; the command was ignored.
- cnt_flat  out  NUM_CH*WIDTH  all counters; counter i occupies [i*WIDTH +: WIDTH].

## Operation
- Op codes:
  - 0 NOP: returns the current value; no change.
  - 1 PRE_INC: +1; returns the new value.
  - 2 POST_INC: +1; returns the old value.
  - 3 PRE_DEC: −1; returns the new value.
  - 4 POST_DEC: −1; returns the old value.
  - 5 LOAD: writes cmd_data; returns the old value.
  - 6 ADD: adds cmd_data; returns the new value.
  - 7 CLR_ALL: zeroes every counter; returns the old value of cmd_idx.
- Arithmetic: modulo 2^WIDTH. rsp_ovf=1 when INC goes from max to 0, DEC goes from 0 to max, or ADD carries out. LOAD, NOP and CLR_ALL always give rsp_ovf=0.
- Out-of-range index:
  - No counter changes.
  - rsp_err=1, rsp_data=0, rsp_ovf=0.
  - CLR_ALL with a bad index still does not clear.
- Response path: single output register. cmd_ready = !rsp_valid || rsp_ready, combinational from rsp_ready.
- Two-state response FSM:
  - IDLE → FULL on accept.
  - FULL → IDLE on consume with no new accept.
  - FULL → FULL on simultaneous consume and accept; the register reloads.
- Reset values: all counters 0, rsp_valid 0, rsp_data 0, rsp_idx 0, rsp_ovf 0, rsp_err 0. Reset mid-operation discards any pending response.

## Timing
- Counter update and response capture occur on the clk edge that accepts the command.
- Latency: rsp_valid rises 1 cycle after acceptance. cnt_flat shows the new value in the same cycle.
- Throughput: 1 command/cycle while rsp_ready is held high.
- Back-to-back commands to the same index need no forwarding: each sees the prior command's result.
- rsp_* outputs stay stable while rsp_valid && !rsp_ready.
- cmd_* inputs are sampled only on accept.

## Configuration
- CNT_BANK_SAT_EN:
  - Defined: INC/ADD clamp at 2^WIDTH−1 and DEC clamps at 0. rsp_ovf=1 when clamping occurred; the counter holds the clamped value.
  - Undefined: modulo wrap as above.
- Op codes, latency and handshake are identical in both builds.

## Structure
- Package cnt_bank_pkg:
  - typedef enum logic [2:0] cnt_op_e, holding the eight op codes.
  - Localparam OP_W=3.
  - Function for "returns new value" classification.
- Sub-module cnt_bank_alu:
  - Purely combinational.
  - Inputs: old value, op, data.
  - Outputs: new value, returned value, ovf.
  - Contains the only wrap/saturation logic, selected by the macro.
- Top level holds the counter array, index decode, response register and handshake.

## Test plan
- Reset, then NOP to each index → rsp_data=0 for each; cnt_flat=0.
- Back-to-back POST_INC, PRE_INC to idx 2 with rsp_ready=1 → responses 0, then 2; counter 2 = 2.
- LOAD 0xFF to idx 1, then PRE_INC:
  - Wrap build → rsp_data=0x00, rsp_ovf=1.
  - CNT_BANK_SAT_EN build → rsp_data=0xFF, rsp_ovf=1.
- NUM_CH=3, PRE_INC to idx 3 → rsp_err=1, rsp_data=0; cnt_flat unchanged.
- rsp_ready=0 for 3 cycles after an accept:
  - cmd_ready=0 throughout.
  - rsp_* stable.
  - Raising rsp_ready with cmd_valid high accepts and responds in consecutive cycles.
- CLR_ALL to idx 0 when counters=5,6,7,8:
  - rsp_data=5; all counters read 0 next cycle.
  - Assert rst_n low with a response pending → rsp_valid=0 immediately.

Source files
------------

// File: rtl/cnt_bank_pkg.sv
// Shared op codes, response FSM states and op classification for the counter bank.
package cnt_bank_pkg;

  localparam int OP_W = 3;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_PRE_INC  = 3'd1,
    OP_POST_INC = 3'd2,
    OP_PRE_DEC  = 3'd3,
    OP_POST_DEC = 3'd4,
    OP_LOAD     = 3'd5,
    OP_ADD      = 3'd6,
    OP_CLR_ALL  = 3'd7
  } cnt_op_e;

  typedef enum logic {
    RSP_IDLE = 1'b0,
    RSP_FULL = 1'b1
  } rsp_state_e;

  // NOP returns the unchanged value, so either classification is correct for it.
  function automatic logic op_returns_new(cnt_op_e op);
    return (op == OP_PRE_INC) || (op == OP_PRE_DEC) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/cnt_bank_alu.sv
// Combinational update for one counter: new value, returned value and overflow.
// Define CNT_BANK_SAT_EN to clamp at the range limits instead of wrapping.
module cnt_bank_alu
  import cnt_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] old_val,
  input  cnt_op_e          op,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] new_val,
  output logic [WIDTH-1:0] ret_val,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH:0] sum;

  always_comb begin
    sum     = {1'b0, old_val} + {1'b0, data};
    new_val = old_val;
    ovf     = 1'b0;
    case (op)
      OP_PRE_INC, OP_POST_INC: begin
        ovf = (old_val == MAX_VAL);
`ifdef CNT_BANK_SAT_EN
        new_val = ovf ? MAX_VAL : old_val + ONE;
`else
        new_val = old_val + ONE;
`endif
      end
      OP_PRE_DEC, OP_POST_DEC: begin
        ovf = (old_val == '0);
`ifdef CNT_BANK_SAT_EN
        new_val = ovf ? '0 : old_val - ONE;
`else
        new_val = old_val - ONE;
`endif
      end
      OP_LOAD: new_val = data;
      OP_ADD: begin
        ovf = sum[WIDTH];
`ifdef CNT_BANK_SAT_EN
        new_val = ovf ? MAX_VAL : sum[WIDTH-1:0];
`else
        new_val = sum[WIDTH-1:0];
`endif
      end
      OP_CLR_ALL: new_val = '0;
      default: new_val = old_val;
    endcase
    ret_val = op_returns_new(op) ? new_val : old_val;
  end

endmodule

// File: rtl/cnt_bank_incdec.sv
// Bank of NUM_CH counters with indexed inc/dec/load/add commands and a one-deep
// response register. Saturating arithmetic is selected with CNT_BANK_SAT_EN.
module cnt_bank_incdec
  import cnt_bank_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic [IDX_W-1:0]        cmd_idx,
  input  logic [WIDTH-1:0]        cmd_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [WIDTH-1:0]        rsp_data,
  output logic [IDX_W-1:0]        rsp_idx,
  output logic                    rsp_ovf,
  output logic                    rsp_err,
  output logic [NUM_CH*WIDTH-1:0] cnt_flat
);

  logic [WIDTH-1:0] cnt_q [NUM_CH];
  logic [WIDTH-1:0] cnt_d [NUM_CH];

  rsp_state_e       state_q, state_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [IDX_W-1:0] rsp_idx_q, rsp_idx_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;

  cnt_op_e          op;
  logic             accept;
  logic             idx_ok;
  logic [WIDTH-1:0] old_val;
  logic [WIDTH-1:0] new_val;
  logic [WIDTH-1:0] ret_val;
  logic             alu_ovf;

  assign op        = cnt_op_e'(cmd_op);
  assign rsp_valid = (state_q == RSP_FULL);
  assign cmd_ready = !rsp_valid || rsp_ready;
  assign accept    = cmd_valid && cmd_ready;
  assign idx_ok    = 32'(cmd_idx) < 32'(NUM_CH);

  // Unmatched indices (only possible when NUM_CH is not a power of two) read as zero.
  always_comb begin
    old_val = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_idx == IDX_W'(i)) old_val = cnt_q[i];
    end
  end

  cnt_bank_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .old_val(old_val),
    .op     (op),
    .data   (cmd_data),
    .new_val(new_val),
    .ret_val(ret_val),
    .ovf    (alu_ovf)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (accept && idx_ok) begin
      if (op == OP_CLR_ALL) begin
        for (int i = 0; i < NUM_CH; i++) cnt_d[i] = '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cmd_idx == IDX_W'(i)) cnt_d[i] = new_val;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_idx_d  = rsp_idx_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_err_d  = rsp_err_q;
    if (accept) begin
      state_d    = RSP_FULL;
      rsp_data_d = idx_ok ? ret_val : '0;
      rsp_idx_d  = cmd_idx;
      rsp_ovf_d  = idx_ok && alu_ovf;
      rsp_err_d  = !idx_ok;
    end else if (rsp_ready) begin
      state_d = RSP_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      state_q    <= RSP_IDLE;
      rsp_data_q <= '0;
      rsp_idx_q  <= '0;
      rsp_ovf_q  <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_CH; i++) cnt_flat[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  assign rsp_data = rsp_data_q;
  assign rsp_idx  = rsp_idx_q;
  assign rsp_ovf  = rsp_ovf_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_cnt_bank_incdec.sv
// Self-checking bench for cnt_bank_incdec: directed steps plus random commands
// against an integer reference model of the counter bank.
module tb_cnt_bank_incdec;

  localparam int NUM_CH = 3;
  localparam int WIDTH  = 8;
  localparam int IDX_W  = 2;
  localparam int MAXV   = (1 << WIDTH) - 1;
`ifdef CNT_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                    clk;
  logic                    rst_n;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2:0]              cmd_op;
  logic [IDX_W-1:0]        cmd_idx;
  logic [WIDTH-1:0]        cmd_data;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [WIDTH-1:0]        rsp_data;
  logic [IDX_W-1:0]        rsp_idx;
  logic                    rsp_ovf;
  logic                    rsp_err;
  logic [NUM_CH*WIDTH-1:0] cnt_flat;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt [NUM_CH];

  cnt_bank_incdec #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_idx  (cmd_idx),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_idx  (rsp_idx),
    .rsp_ovf  (rsp_ovf),
    .rsp_err  (rsp_err),
    .cnt_flat (cnt_flat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, then wrap or clamp anything out of range.
  function automatic void model_exec(input int op, input int idx, input int data,
                                     output int r_data, output int r_ovf, output int r_err);
    int old_v;
    int n;
    r_data = 0;
    r_ovf  = 0;
    r_err  = 0;
    if (idx >= NUM_CH) begin
      r_err = 1;
      return;
    end
    old_v = model_cnt[idx];
    case (op)
      1, 2:    n = old_v + 1;
      3, 4:    n = old_v - 1;
      5:       n = data;
      6:       n = old_v + data;
      default: n = old_v;
    endcase
    if (n > MAXV) begin
      r_ovf = 1;
      n = SAT ? MAXV : n - (MAXV + 1);
    end else if (n < 0) begin
      r_ovf = 1;
      n = SAT ? 0 : MAXV;
    end
    if (op == 7) begin
      for (int i = 0; i < NUM_CH; i++) model_cnt[i] = 0;
      r_data = old_v;
    end else begin
      model_cnt[idx] = n;
      r_data = (op == 1 || op == 3 || op == 6) ? n : old_v;
    end
  endfunction

  function automatic logic [NUM_CH*WIDTH-1:0] model_flat();
    logic [NUM_CH*WIDTH-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_CH; i++) f[i*WIDTH +: WIDTH] = WIDTH'(model_cnt[i]);
    return f;
  endfunction

  task automatic check_rsp(input string tag, input int e_data, input int e_ovf,
                           input int e_err, input int e_idx);
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_data, e_data);
    check({tag, "_ovf"}, rsp_ovf, e_ovf);
    check({tag, "_err"}, rsp_err, e_err);
    check({tag, "_idx"}, rsp_idx, e_idx);
    check({tag, "_flat"}, cnt_flat, model_flat());
  endtask

  // Called just after a rising edge; leaves the command asserted for back-to-back use.
  task automatic send(input logic [2:0] op, input logic [IDX_W-1:0] idx,
                      input logic [WIDTH-1:0] data, input string tag);
    int ed, eo, ee;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_data  = data;
    rsp_ready = 1'b1;
    #1;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    model_exec(int'(op), int'(idx), int'(data), ed, eo, ee);
    check_rsp(tag, ed, eo, ee, int'(idx));
  endtask

  task automatic idle(input string tag);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drained"}, rsp_valid, 0);
  endtask

  initial begin
    int sd, so, se;
    logic [WIDTH-1:0] held_data;
    logic [2:0]       r_op;
    logic [IDX_W-1:0] r_idx;

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_idx   = '0;
    cmd_data  = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) model_cnt[i] = 0;

    #2;
    check("rst_valid", rsp_valid, 0);
    check("rst_data", rsp_data, 0);
    check("rst_idx", rsp_idx, 0);
    check("rst_ovf", rsp_ovf, 0);
    check("rst_err", rsp_err, 0);
    check("rst_flat", cnt_flat, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < NUM_CH; i++) send(3'd0, IDX_W'(i), 8'h00, "nop");
    send(3'd2, 2'd2, 8'h00, "post_inc2");
    check("post_inc2_const", rsp_data, 0);
    send(3'd1, 2'd2, 8'h00, "pre_inc2");
    check("pre_inc2_const", rsp_data, 2);
    check("cnt2_const", cnt_flat[2*WIDTH +: WIDTH], 2);

    send(3'd5, 2'd1, 8'hFF, "load_ff");
    send(3'd1, 2'd1, 8'h00, "inc_ff");
    check("inc_ff_const_data", rsp_data, SAT ? 8'hFF : 8'h00);
    check("inc_ff_const_ovf", rsp_ovf, 1);
    send(3'd4, 2'd0, 8'h00, "dec_zero");
    send(3'd6, 2'd2, 8'hFE, "add_carry");

    send(3'd1, 2'd3, 8'h00, "bad_idx");
    check("bad_idx_const_err", rsp_err, 1);
    send(3'd7, 2'd3, 8'h00, "bad_clr");
    idle("pre_stall");

    // Stall the response for three cycles while a second command waits.
    cmd_valid = 1'b1;
    cmd_op    = 3'd6;
    cmd_idx   = 2'd0;
    cmd_data  = 8'h33;
    rsp_ready = 1'b0;
    #1;
    check("stall_first_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    model_exec(6, 0, 'h33, sd, so, se);
    check_rsp("stall_first", sd, so, se, 0);
    held_data = rsp_data;
    cmd_op    = 3'd4;
    cmd_idx   = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_valid", rsp_valid, 1);
      check("stall_data", rsp_data, sd);
      check("stall_idx", rsp_idx, 0);
      check("stall_ovf", rsp_ovf, so);
      @(posedge clk);
      #1;
      check("stall_flat", cnt_flat, model_flat());
      check("stall_held", rsp_data, held_data);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    model_exec(4, 1, 0, sd, so, se);
    check_rsp("release", sd, so, se, 1);
    idle("post_release");

    send(3'd5, 2'd0, 8'd5, "ld5");
    send(3'd5, 2'd1, 8'd6, "ld6");
    send(3'd5, 2'd2, 8'd7, "ld7");
    send(3'd7, 2'd0, 8'h00, "clr_all");
    check("clr_all_const_data", rsp_data, 5);
    check("clr_all_const_flat", cnt_flat, 0);

    for (int n = 0; n < 300; n++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_idx = IDX_W'($urandom_range(0, 3));
      if (r_op == 3'd7 && $urandom_range(0, 3) != 0) r_op = 3'd6;
      send(r_op, r_idx, 8'($urandom), "rand");
    end
    idle("post_rand");

    // Reset with a response pending must drop it immediately.
    cmd_valid = 1'b1;
    cmd_op    = 3'd1;
    cmd_idx   = 2'd0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    check("pend_valid", rsp_valid, 1);
    cmd_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_data", rsp_data, 0);
    check("mid_rst_flat", cnt_flat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
